servo_sweep_ctrl: RTL and testbench

Angle sequencer for the radar scan head: steps the servo through 0..ANGLE_MAX degrees in a ping-pong sweep. At each angle it computes the PWM high time, waits for mechanical settling, then performs a request/done handshake with the ranging stage. Sits directly upstream of the servo PWM generator, which consumes `pulse_width` as its high-time compare value against its 20-bit frame counter.

---
 rtl/servo_sweep_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_servo_sweep_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_sweep_ctrl.sv
// Purpose : ping-pong angle sequencer for the radar scan head. Steps the servo
//           0..ANGLE_MAX..0, derives the PWM high time for each angle, waits
//           for mechanical settling, then runs a req/done handshake with the
//           ranging stage.
// Latency : meas_req rises SETTLE_CYCLES edges after SETTLE entry; point_valid
//           one edge after meas_done is sampled; new angle one edge later.
// Backpr. : the sweep stalls in MEASURE until meas_done (or the optional
//           timeout); enable low parks it in IDLE with angle/dir held.
//
// Ports   : clk, rst (async, active high)
//           enable       - run the sweep
//           meas_done    - ranging stage finished (only looked at in MEASURE)
//           meas_req     - level request, high for the whole MEASURE state
//           angle        - current angle in degrees
//           pulse_width  - servo high time in clk cycles (stable outside STEP)
//           dir          - 0 = increasing, 1 = decreasing
//           point_valid  - one-cycle strobe: angle holds a completed measurement
//           meas_timeout - one-cycle strobe: handshake aborted
//
// Build option: define SERVO_SWEEP_TIMEOUT_EN to abort a handshake after
// MEAS_TIMEOUT cycles; otherwise MEASURE waits forever and meas_timeout is 0.

module servo_sweep_ctrl #(
  parameter int unsigned BASE_WIDTH    = 16000,
  parameter int unsigned WIDTH_PER_DEG = 277,
  parameter int unsigned ANGLE_MAX     = 180,
  parameter int unsigned SETTLE_CYCLES = 2700000,
  parameter int unsigned MEAS_TIMEOUT  = 1350000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        meas_done,
  output logic        meas_req,
  output logic [7:0]  angle,
  output logic [19:0] pulse_width,
  output logic        dir,
  output logic        point_valid,
  output logic        meas_timeout
);

  // One counter serves both the settle wait and (when built in) the handshake
  // timeout; it is cleared on entry to each state, so it is sized for the
  // larger of the two limits.
  localparam int unsigned CNT_LIMIT = (SETTLE_CYCLES > MEAS_TIMEOUT) ? SETTLE_CYCLES : MEAS_TIMEOUT;
  localparam int          CW        = (CNT_LIMIT > 1) ? $clog2(CNT_LIMIT) : 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    AMAX        = 8'(ANGLE_MAX);
  localparam logic [19:0]   BASE_W      = 20'(BASE_WIDTH);
  localparam logic [19:0]   STEP_W      = 20'(WIDTH_PER_DEG);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    STEP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    angle_q, angle_d;
  logic          dir_q, dir_d;
  logic [19:0]   pw_q, pw_d;
  logic          pv_q, pv_d;

`ifdef SERVO_SWEEP_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(MEAS_TIMEOUT - 1);
  logic to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    angle_d = angle_q;
    dir_d   = dir_q;
    pw_d    = pw_q;
    pv_d    = 1'b0;
`ifdef SERVO_SWEEP_TIMEOUT_EN
    to_d    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end

      SETTLE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      MEASURE: begin
        // meas_done is checked first so it wins over a coincident timeout.
        if (meas_done) begin
          pv_d    = 1'b1;
          state_d = enable ? STEP : IDLE;
`ifdef SERVO_SWEEP_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_LAST) begin
          to_d    = 1'b1;
          state_d = enable ? STEP : IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end

      STEP: begin
        // Endpoints reverse in place: the next point is one step back inside
        // the range, so each endpoint is measured once per reversal.
        if (!dir_q) begin
          if (angle_q < AMAX) begin
            angle_d = angle_q + 8'd1;
          end else begin
            dir_d   = 1'b1;
            angle_d = AMAX - 8'd1;
          end
        end else begin
          if (angle_q != 8'd0) begin
            angle_d = angle_q - 8'd1;
          end else begin
            dir_d   = 1'b0;
            angle_d = 8'd1;
          end
        end
        // Only place the PWM compare value moves, so the servo sees a stable
        // width for the whole settle interval.
        pw_d    = BASE_W + ({12'd0, angle_d} * STEP_W);
        state_d = SETTLE;
        cnt_d   = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      angle_q <= 8'd0;
      dir_q   <= 1'b0;
      pw_q    <= BASE_W;
      pv_q    <= 1'b0;
`ifdef SERVO_SWEEP_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      angle_q <= angle_d;
      dir_q   <= dir_d;
      pw_q    <= pw_d;
      pv_q    <= pv_d;
`ifdef SERVO_SWEEP_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  // Decoded straight from the state register so reset drops it immediately.
  assign meas_req    = (state_q == MEASURE);
  assign angle       = angle_q;
  assign dir         = dir_q;
  assign pulse_width = pw_q;
  assign point_valid = pv_q;
`ifdef SERVO_SWEEP_TIMEOUT_EN
  assign meas_timeout = to_q;
`else
  assign meas_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// Bench for servo_sweep_ctrl: randomized handshake latencies and enable drops,
// checked against a triangle-wave model of the sweep (point n -> angle).

module tb_servo_sweep_ctrl;

  localparam int AM   = 180;
  localparam int ST   = 10;
  localparam int TO   = 20;
  localparam int BASE = 16000;
  localparam int WPD  = 277;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        meas_done;
  logic        meas_req;
  logic [7:0]  angle;
  logic [19:0] pulse_width;
  logic        dir;
  logic        point_valid;
  logic        meas_timeout;

  int total = 0;
  int bad   = 0;
  int idx   = 0;  // number of completed STEPs since reset (model position)

  always #5 clk = ~clk;

  servo_sweep_ctrl #(
    .BASE_WIDTH   (BASE),
    .WIDTH_PER_DEG(WPD),
    .ANGLE_MAX    (AM),
    .SETTLE_CYCLES(ST),
    .MEAS_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .meas_done   (meas_done),
    .meas_req    (meas_req),
    .angle       (angle),
    .pulse_width (pulse_width),
    .dir         (dir),
    .point_valid (point_valid),
    .meas_timeout(meas_timeout)
  );

  // Sweep model: point n lies on a triangle wave of period 2*AM.
  function automatic int exp_angle(input int n);
    int p;
    p = n % (2 * AM);
    return (p <= AM) ? p : (2 * AM - p);
  endfunction

  function automatic logic exp_dir(input int n);
    int p;
    p = n % (2 * AM);
    return (p > AM) || (p == 0 && n > 0);
  endfunction

  function automatic int exp_pw(input int n);
    return BASE + exp_angle(n) * WPD;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: waits for meas_req, holds off lat cycles, answers, and
  // reports what the DUT showed at the point_valid cycle and one cycle later.
  task automatic serve_point(input int lat, output int wait_cyc, output logic pw_stable,
                             output logic pv, output logic [7:0] ang, output logic d,
                             output logic [19:0] pw, output logic req_after,
                             output logic [7:0] ang_n, output logic [19:0] pw_n);
    logic [19:0] pw0;
    pw0       = pulse_width;
    pw_stable = 1'b1;
    wait_cyc  = 0;
    while (meas_req !== 1'b1 && wait_cyc < 200) begin
      tick();
      wait_cyc++;
      if (pulse_width !== pw0) pw_stable = 1'b0;
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      if (pulse_width !== pw0) pw_stable = 1'b0;
    end
    meas_done = 1'b1;
    tick();
    pv        = point_valid;
    ang       = angle;
    d         = dir;
    pw        = pulse_width;
    req_after = meas_req;
    if (pulse_width !== pw0) pw_stable = 1'b0;
    meas_done = 1'b0;
    tick();
    ang_n = angle;
    pw_n  = pulse_width;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; meas_done = 1'b0;
    #3;
    total++; if (angle !== 8'd0) begin bad++; $display("FAIL reset_angle got=%0d exp=0", angle); end
    total++; if (pulse_width !== 20'd16000) begin bad++; $display("FAIL reset_pw got=%0d exp=16000", pulse_width); end
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL reset_dir got=%b exp=0", dir); end
    total++; if (meas_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", meas_req); end
    total++; if (point_valid !== 1'b0) begin bad++; $display("FAIL reset_pv got=%b exp=0", point_valid); end
    total++; if (meas_timeout !== 1'b0) begin bad++; $display("FAIL reset_mto got=%b exp=0", meas_timeout); end
  endtask

  task automatic test_settle_latency();
    int w; logic st, pv, d, ra; logic [7:0] a, an; logic [19:0] pw, pwn;
    enable = 1'b1;
    tick();
    rst = 1'b0;
    tick();  // IDLE -> SETTLE on this edge
    idx = 0;
    serve_point(3, w, st, pv, a, d, pw, ra, an, pwn);
    total++; if (w !== ST) begin bad++; $display("FAIL lat_req_rise got=%0d exp=%0d", w, ST); end
    total++; if (pv !== 1'b1) begin bad++; $display("FAIL lat_pv got=%b exp=1", pv); end
    total++; if (a !== 8'd0) begin bad++; $display("FAIL lat_angle got=%0d exp=0", a); end
    total++; if (pw !== 20'd16000) begin bad++; $display("FAIL lat_pw got=%0d exp=16000", pw); end
    total++; if (ra !== 1'b0) begin bad++; $display("FAIL lat_req_drop got=%b exp=0", ra); end
    total++; if (an !== 8'd1) begin bad++; $display("FAIL lat_next_angle got=%0d exp=1", an); end
    total++; if (pwn !== 20'd16277) begin bad++; $display("FAIL lat_next_pw got=%0d exp=16277", pwn); end
    idx++;
  endtask

  task automatic test_done_outside();
    int w; logic st, pv, d, ra, pv_seen; logic [7:0] a, an; logic [19:0] pw, pwn;
    pv_seen = 1'b0;
    meas_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (point_valid === 1'b1) pv_seen = 1'b1;
    end
    meas_done = 1'b0;
    total++; if (pv_seen !== 1'b0) begin bad++; $display("FAIL ignore_done_pv got=%b exp=0", pv_seen); end
    serve_point(0, w, st, pv, a, d, pw, ra, an, pwn);
    total++; if (w !== ST - 5) begin bad++; $display("FAIL ignore_done_wait got=%0d exp=%0d", w, ST - 5); end
    total++; if (pv !== 1'b1) begin bad++; $display("FAIL ignore_done_then_pv got=%b exp=1", pv); end
    total++; if (a !== exp_angle(idx)) begin bad++; $display("FAIL ignore_done_angle got=%0d exp=%0d", a, exp_angle(idx)); end
    total++; if (an !== exp_angle(idx + 1)) begin bad++; $display("FAIL ignore_done_next got=%0d exp=%0d", an, exp_angle(idx + 1)); end
    idx++;
  endtask

  task automatic test_enable_drop_settle();
    int w, nreq; logic st, pv, d, ra; logic [7:0] a, an; logic [19:0] pw, pwn;
    repeat ($urandom_range(1, 8)) tick();
    enable = 1'b0;
    tick();
    nreq = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (meas_req !== 1'b0) nreq++;
    end
    total++; if (nreq !== 0) begin bad++; $display("FAIL settle_drop_req got=%0d exp=0", nreq); end
    total++; if (angle !== exp_angle(idx)) begin bad++; $display("FAIL settle_drop_angle got=%0d exp=%0d", angle, exp_angle(idx)); end
    enable = 1'b1;
    tick();
    serve_point($urandom_range(0, 4), w, st, pv, a, d, pw, ra, an, pwn);
    total++; if (w !== ST) begin bad++; $display("FAIL settle_restart_wait got=%0d exp=%0d", w, ST); end
    total++; if (a !== exp_angle(idx)) begin bad++; $display("FAIL settle_restart_angle got=%0d exp=%0d", a, exp_angle(idx)); end
    total++; if (an !== exp_angle(idx + 1)) begin bad++; $display("FAIL settle_restart_next got=%0d exp=%0d", an, exp_angle(idx + 1)); end
    idx++;
  endtask

  task automatic test_enable_drop_measure();
    int w, nreq, nchg; logic held;
    w = 0;
    while (meas_req !== 1'b1 && w < 200) begin tick(); w++; end
    total++; if (w !== ST) begin bad++; $display("FAIL meas_drop_wait got=%0d exp=%0d", w, ST); end
    enable = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (meas_req !== 1'b1) held = 1'b0;
    end
    total++; if (held !== 1'b1) begin bad++; $display("FAIL meas_drop_req_held got=%b exp=1", held); end
    meas_done = 1'b1;
    tick();
    meas_done = 1'b0;
    total++; if (point_valid !== 1'b1) begin bad++; $display("FAIL meas_drop_pv got=%b exp=1", point_valid); end
    total++; if (angle !== exp_angle(idx)) begin bad++; $display("FAIL meas_drop_pv_angle got=%0d exp=%0d", angle, exp_angle(idx)); end
    nreq = 0; nchg = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (meas_req !== 1'b0) nreq++;
      if (angle !== exp_angle(idx)) nchg++;
    end
    total++; if (nreq !== 0) begin bad++; $display("FAIL meas_drop_idle_req got=%0d exp=0", nreq); end
    total++; if (nchg !== 0) begin bad++; $display("FAIL meas_drop_angle_held got=%0d exp=0", nchg); end
    enable = 1'b1;
    tick();  // back into SETTLE; same angle is measured again
  endtask

  task automatic test_timeout();
    int w, c; logic pv_seen;
    w = 0;
    while (meas_req !== 1'b1 && w < 200) begin tick(); w++; end
    total++; if (w !== ST) begin bad++; $display("FAIL to_wait got=%0d exp=%0d", w, ST); end
`ifdef SERVO_SWEEP_TIMEOUT_EN
    c = 0; pv_seen = 1'b0;
    while (meas_timeout !== 1'b1 && c < 100) begin
      tick(); c++;
      if (point_valid === 1'b1) pv_seen = 1'b1;
    end
    total++; if (c !== TO) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", c, TO); end
    total++; if (pv_seen !== 1'b0) begin bad++; $display("FAIL to_pv got=%b exp=0", pv_seen); end
    total++; if (meas_req !== 1'b0) begin bad++; $display("FAIL to_req_drop got=%b exp=0", meas_req); end
    tick();
    total++; if (meas_timeout !== 1'b0) begin bad++; $display("FAIL to_one_cycle got=%b exp=0", meas_timeout); end
    total++; if (angle !== exp_angle(idx + 1)) begin bad++; $display("FAIL to_advance got=%0d exp=%0d", angle, exp_angle(idx + 1)); end
    idx++;
`else
    c = 0; pv_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (meas_timeout !== 1'b0) c++;
      if (meas_req !== 1'b1) pv_seen = 1'b1;
    end
    total++; if (c !== 0) begin bad++; $display("FAIL no_to_strobe got=%0d exp=0", c); end
    total++; if (pv_seen !== 1'b0) begin bad++; $display("FAIL no_to_req_held got=%b exp=0", pv_seen); end
    meas_done = 1'b1;
    tick();
    meas_done = 1'b0;
    total++; if (point_valid !== 1'b1) begin bad++; $display("FAIL no_to_pv got=%b exp=1", point_valid); end
    tick();
    total++; if (angle !== exp_angle(idx + 1)) begin bad++; $display("FAIL no_to_advance got=%0d exp=%0d", angle, exp_angle(idx + 1)); end
    idx++;
`endif
  endtask

  task automatic test_sweep();
    int w; logic st, pv, d, ra; logic [7:0] a, an; logic [19:0] pw, pwn;
    while (idx < 2 * AM + 3) begin
      serve_point($urandom_range(0, 4), w, st, pv, a, d, pw, ra, an, pwn);
      total++; if (w !== ST) begin bad++; $display("FAIL sweep_wait n=%0d got=%0d exp=%0d", idx, w, ST); end
      total++; if (st !== 1'b1) begin bad++; $display("FAIL sweep_pw_stable n=%0d got=%b exp=1", idx, st); end
      total++; if (pv !== 1'b1) begin bad++; $display("FAIL sweep_pv n=%0d got=%b exp=1", idx, pv); end
      total++; if (a !== exp_angle(idx)) begin bad++; $display("FAIL sweep_angle n=%0d got=%0d exp=%0d", idx, a, exp_angle(idx)); end
      total++; if (d !== exp_dir(idx)) begin bad++; $display("FAIL sweep_dir n=%0d got=%b exp=%b", idx, d, exp_dir(idx)); end
      total++; if (pw !== exp_pw(idx)) begin bad++; $display("FAIL sweep_pw n=%0d got=%0d exp=%0d", idx, pw, exp_pw(idx)); end
      total++; if (ra !== 1'b0) begin bad++; $display("FAIL sweep_req_drop n=%0d got=%b exp=0", idx, ra); end
      total++; if (an !== exp_angle(idx + 1)) begin bad++; $display("FAIL sweep_next_angle n=%0d got=%0d exp=%0d", idx, an, exp_angle(idx + 1)); end
      total++; if (pwn !== exp_pw(idx + 1)) begin bad++; $display("FAIL sweep_next_pw n=%0d got=%0d exp=%0d", idx, pwn, exp_pw(idx + 1)); end
      if (exp_angle(idx) == AM) begin
        total++; if (pw !== 20'd65860) begin bad++; $display("FAIL max_width got=%0d exp=65860", pw); end
      end
      idx++;
    end
  endtask

  task automatic test_reset_async();
    int w;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    total++; if (angle !== 8'd0) begin bad++; $display("FAIL async_settle_angle got=%0d exp=0", angle); end
    total++; if (pulse_width !== 20'd16000) begin bad++; $display("FAIL async_settle_pw got=%0d exp=16000", pulse_width); end
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL async_settle_dir got=%b exp=0", dir); end
    rst = 1'b0;
    tick();  // IDLE -> SETTLE
    w = 0;
    while (meas_req !== 1'b1 && w < 200) begin tick(); w++; end
    total++; if (w !== ST) begin bad++; $display("FAIL async_restart_wait got=%0d exp=%0d", w, ST); end
    #2 rst = 1'b1;
    #1;
    total++; if (meas_req !== 1'b0) begin bad++; $display("FAIL async_meas_req got=%b exp=0", meas_req); end
    total++; if (point_valid !== 1'b0) begin bad++; $display("FAIL async_meas_pv got=%b exp=0", point_valid); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_settle_latency();
    test_done_outside();
    test_enable_drop_settle();
    test_enable_drop_measure();
    test_timeout();
    test_sweep();
    test_reset_async();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
